wfg_wb_cfg_master: RTL and testbench

Wishbone classic initiator that replays a register configuration script stored in the memory macro into the wfg Wishbone slave space (0x3000_0xx0). Each script entry is an address word followed by a data word. An entry either writes a register or reads one back and checks it against an expected value. The block sits beside the wfg slave fabric and drives its io_wbs_* inputs, so the whole generator can be configured without the host CPU.

---
 rtl/wfg_wb_cfg_master_if.sv | 24 ++
 rtl/wfg_wb_cfg_master.sv | 164 ++++++++++++++++
 tb/tb_wfg_wb_cfg_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wfg_wb_cfg_master_if.sv
// Wishbone classic master-to-slave bundle for the wfg configuration initiator.
// Signal directions are named from the master's point of view.
interface wfg_wb_cfg_master_if #(
  parameter int BUSW = 32
);
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [3:0]      wbm_sel_o;
  logic [BUSW-1:0] wbm_adr_o;
  logic [BUSW-1:0] wbm_dat_o;
  logic [BUSW-1:0] wbm_dat_i;
  logic            wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wfg_wb_cfg_master.sv
// Replays an address/data configuration script from the memory macro onto the
// wfg Wishbone slave space, with read-back checking, timeout and overrun detection.
module wfg_wb_cfg_master #(
  parameter int BUSW    = 32,
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start_i,
  input  logic [MEM_AW-1:0]    base_addr_i,
  output logic                 csb1,
  output logic [MEM_AW-1:0]    addr1,
  input  logic [31:0]          dout1,
  wfg_wb_cfg_master_if.master  wbm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [MEM_AW-1:0]    err_addr_o
);

  localparam int                TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [MEM_AW-1:0] PTR_MAX = '1;
  localparam logic [1:0]        OP_READ = 2'b01;
  localparam logic [1:0]        OP_END  = 2'b11;
  localparam logic [1:0]        ERR_TMO = 2'b01;
  localparam logic [1:0]        ERR_CMP = 2'b10;
  localparam logic [1:0]        ERR_OVR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_A, CAP_A, RD_D, CAP_D, WB, NEXT, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [MEM_AW-1:0] entry_q, entry_d;
  logic [MEM_AW-1:0] err_addr_q, err_addr_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              err_q, err_d;
  logic [BUSW-1:0]   adr_q, adr_d;
  logic [BUSW-1:0]   dat_q, dat_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      entry_q    <= '0;
      err_addr_q <= '0;
      op_q       <= '0;
      err_code_q <= '0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      entry_q    <= entry_d;
      err_addr_q <= err_addr_d;
      op_q       <= op_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    entry_d    = entry_q;
    err_addr_d = err_addr_q;
    op_d       = op_q;
    err_code_d = err_code_q;
    err_d      = err_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d      = base_addr_i;
          err_d      = 1'b0;
          err_code_d = '0;
          state_d    = RD_A;
        end
      end
      RD_A: state_d = CAP_A;
      CAP_A: begin
        entry_d = ptr_q;
        op_d    = dout1[1:0];
        adr_d   = BUSW'({dout1[31:2], 2'b00});
        if (dout1[1:0] == OP_END) begin
          state_d = FIN;
        end else if (ptr_q == PTR_MAX) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVR;
          err_addr_d = ptr_q;
          state_d    = FIN;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = RD_D;
        end
      end
      RD_D: state_d = CAP_D;
      CAP_D: begin
        dat_d   = BUSW'(dout1);
        tmo_d   = '0;
        state_d = WB;
      end
      WB: begin
        // The ack cycle is the only point where slave read data is trusted.
        if (wbm.wbm_ack_i) begin
          if (op_q == OP_READ && wbm.wbm_dat_i != dat_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_CMP;
            err_addr_d = entry_q;
            state_d    = FIN;
          end else begin
            state_d = NEXT;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          err_addr_d = entry_q;
          state_d    = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      NEXT: begin
        if (ptr_q == PTR_MAX) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVR;
          err_addr_d = entry_q;
          state_d    = FIN;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = RD_A;
        end
      end
      FIN: state_d = IDLE;
    endcase
  end

  assign csb1          = !(state_q == RD_A || state_q == RD_D);
  assign addr1         = ptr_q;
  assign wbm.wbm_cyc_o = (state_q == WB);
  assign wbm.wbm_stb_o = (state_q == WB);
  assign wbm.wbm_we_o  = (state_q == WB) && (op_q != OP_READ);
  assign wbm.wbm_sel_o = 4'hF;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == FIN);
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_wfg_wb_cfg_master.sv
// Directed bench for wfg_wb_cfg_master: script memory model, Wishbone slave model
// with programmable wait states, and hand-computed expectations per run.
module tb_wfg_wb_cfg_master;

  logic        clk = 1'b0;
  logic        wb_rst_ni;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic        csb1;
  logic [9:0]  addr1;
  logic [31:0] dout1;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [9:0]  err_addr_o;

  wfg_wb_cfg_master_if #(.BUSW(32)) wbIf ();

  wfg_wb_cfg_master #(.BUSW(32), .MEM_AW(10), .TIMEOUT(64)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (wb_rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .wbm         (wbIf),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .err_addr_o  (err_addr_o)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mem [1024];
  always @(posedge clk) if (!csb1) dout1 <= mem[addr1];

  int fetchTotal = 0;
  int wrapFetch  = 0;
  always @(negedge clk) begin
    if (!csb1) begin
      fetchTotal++;
      if (addr1 == 10'd0) wrapFetch++;
    end
  end

  // Slave model: ack after ackDelay wait states, logs every acked transfer.
  bit          ackQ;
  bit [31:0]   rdatQ;
  bit          noAck;
  int          ackDelay;
  logic [31:0] readData;
  int          waitCnt, stbLen, lastStbLen;
  int          stbAfterAck = 0;
  int          unstable    = 0;
  int          txTotal     = 0;
  logic [31:0] holdAdr, holdDat;
  logic [31:0] logAdr [64];
  logic [31:0] logDat [64];
  logic        logWe  [64];

  assign wbIf.wbm_ack_i = ackQ;
  assign wbIf.wbm_dat_i = rdatQ;

  always @(negedge clk) begin
    if (ackQ) begin
      ackQ  = 1'b0;
      rdatQ = '0;
      if (wbIf.wbm_stb_o === 1'b1) stbAfterAck++;
    end else if (wbIf.wbm_cyc_o === 1'b1 && wbIf.wbm_stb_o === 1'b1) begin
      if (stbLen == 0) begin
        holdAdr = wbIf.wbm_adr_o;
        holdDat = wbIf.wbm_dat_o;
      end else if (wbIf.wbm_adr_o !== holdAdr || wbIf.wbm_dat_o !== holdDat) begin
        unstable++;
      end
      stbLen++;
      if (!noAck && waitCnt == ackDelay) begin
        ackQ = 1'b1;
        if (!wbIf.wbm_we_o) rdatQ = readData;
        logAdr[txTotal] = wbIf.wbm_adr_o;
        logDat[txTotal] = wbIf.wbm_dat_o;
        logWe[txTotal]  = wbIf.wbm_we_o;
        txTotal++;
      end else begin
        waitCnt++;
      end
    end
    if (wbIf.wbm_stb_o !== 1'b1 && stbLen != 0) begin
      lastStbLen = stbLen;
      stbLen     = 0;
      waitCnt    = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] base);
    base_addr_i = base;
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int startCount, output int cycles);
    cycles = startCount;
    while (done_o !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " done seen"}, 32'(done_o), 32'd1);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, 32'(done_o), 32'd0);
    checkOutput({tag, " busy low"}, 32'(busy_o), 32'd0);
  endtask

  task automatic runScript1(input string tag, input int delay, input int expCycles, input int startCount);
    int cyc, txBase, aBase, uBase;
    txBase = txTotal;
    aBase  = stbAfterAck;
    uBase  = unstable;
    waitDone(tag, startCount, cyc);
    checkOutput({tag, " cycles"}, 32'(cyc), 32'(expCycles));
    checkOutput({tag, " tx count"}, 32'(txTotal - txBase), 32'd2);
    checkOutput({tag, " tx0 adr"}, logAdr[txBase], 32'h3000_0010);
    checkOutput({tag, " tx0 dat"}, logDat[txBase], 32'h0000_0001);
    checkOutput({tag, " tx0 we"}, 32'(logWe[txBase]), 32'd1);
    checkOutput({tag, " tx1 adr"}, logAdr[txBase+1], 32'h3000_0050);
    checkOutput({tag, " tx1 dat"}, logDat[txBase+1], 32'h0000_00A5);
    checkOutput({tag, " tx1 we"}, 32'(logWe[txBase+1]), 32'd1);
    checkOutput({tag, " stb len"}, 32'(lastStbLen), 32'(delay + 1));
    checkOutput({tag, " stb after ack"}, 32'(stbAfterAck - aBase), 32'd0);
    checkOutput({tag, " adr/dat stable"}, 32'(unstable - uBase), 32'd0);
    checkOutput({tag, " err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    int cyc, txBase, fBase, wBase;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'h3000_0010; mem[10'h011] = 32'h0000_0001;
    mem[10'h012] = 32'h3000_0052; mem[10'h013] = 32'h0000_00A5;
    mem[10'h014] = 32'h0000_0003;
    mem[10'h040] = 32'h3000_0035; mem[10'h041] = 32'h0000_1234;
    mem[10'h042] = 32'h3000_0020; mem[10'h043] = 32'h0000_0077;
    mem[10'h044] = 32'h0000_0003;
    mem[10'h080] = 32'h3000_0060; mem[10'h081] = 32'h0000_DEAD;
    mem[10'h082] = 32'h0000_0003;
    mem[10'h3FE] = 32'h3000_0070; mem[10'h3FF] = 32'h0000_0055;
    wb_rst_ni   = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    noAck       = 1'b0;
    ackDelay    = 0;
    readData    = '0;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst csb1", 32'(csb1), 32'd1);
    checkOutput("rst addr1", 32'(addr1), 32'd0);
    checkOutput("rst cyc", 32'(wbIf.wbm_cyc_o), 32'd0);
    checkOutput("rst stb", 32'(wbIf.wbm_stb_o), 32'd0);
    checkOutput("rst we", 32'(wbIf.wbm_we_o), 32'd0);
    checkOutput("rst sel", 32'(wbIf.wbm_sel_o), 32'hF);
    checkOutput("rst adr", wbIf.wbm_adr_o, 32'd0);
    checkOutput("rst dat", wbIf.wbm_dat_o, 32'd0);
    checkOutput("rst busy", 32'(busy_o), 32'd0);
    checkOutput("rst done", 32'(done_o), 32'd0);
    checkOutput("rst err", 32'(err_o), 32'd0);
    checkOutput("rst err_code", 32'(err_code_o), 32'd0);
    checkOutput("rst err_addr", 32'(err_addr_o), 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge clk);

    $display("[TB] two-write script, zero wait states");
    applyStimulus(10'h010);
    checkOutput("s1 busy", 32'(busy_o), 32'd1);
    runScript1("s1", 0, 15, 1);

    $display("[TB] read-check, matching data");
    readData = 32'h0000_1234;
    txBase   = txTotal;
    applyStimulus(10'h040);
    waitDone("rc1", 1, cyc);
    checkOutput("rc1 cycles", 32'(cyc), 32'd15);
    checkOutput("rc1 tx count", 32'(txTotal - txBase), 32'd2);
    checkOutput("rc1 rd adr", logAdr[txBase], 32'h3000_0034);
    checkOutput("rc1 rd we", 32'(logWe[txBase]), 32'd0);
    checkOutput("rc1 wr adr", logAdr[txBase+1], 32'h3000_0020);
    checkOutput("rc1 wr dat", logDat[txBase+1], 32'h0000_0077);
    checkOutput("rc1 err", 32'(err_o), 32'd0);

    $display("[TB] read-check, mismatching data");
    readData = 32'h0000_1235;
    txBase   = txTotal;
    applyStimulus(10'h040);
    waitDone("rc2", 1, cyc);
    checkOutput("rc2 cycles", 32'(cyc), 32'd6);
    checkOutput("rc2 tx count", 32'(txTotal - txBase), 32'd1);
    checkOutput("rc2 err", 32'(err_o), 32'd1);
    checkOutput("rc2 err_code", 32'(err_code_o), 32'd2);
    checkOutput("rc2 err_addr", 32'(err_addr_o), 32'h040);

    $display("[TB] two-write script, five wait states");
    ackDelay = 5;
    applyStimulus(10'h010);
    runScript1("s1d5", 5, 25, 1);
    ackDelay = 0;

    $display("[TB] slave never acks");
    noAck  = 1'b1;
    txBase = txTotal;
    applyStimulus(10'h080);
    waitDone("tmo", 1, cyc);
    checkOutput("tmo cycles", 32'(cyc), 32'd69);
    checkOutput("tmo stb len", 32'(lastStbLen), 32'd64);
    checkOutput("tmo tx count", 32'(txTotal - txBase), 32'd0);
    checkOutput("tmo err", 32'(err_o), 32'd1);
    checkOutput("tmo err_code", 32'(err_code_o), 32'd1);
    checkOutput("tmo err_addr", 32'(err_addr_o), 32'h080);
    noAck = 1'b0;

    $display("[TB] start pulse while busy");
    applyStimulus(10'h010);
    repeat (2) @(negedge clk);
    base_addr_i = 10'h080;
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
    runScript1("busy", 0, 15, 4);

    $display("[TB] memory overrun");
    txBase = txTotal;
    fBase  = fetchTotal;
    wBase  = wrapFetch;
    applyStimulus(10'h3FE);
    waitDone("ovr", 1, cyc);
    checkOutput("ovr cycles", 32'(cyc), 32'd7);
    checkOutput("ovr tx count", 32'(txTotal - txBase), 32'd1);
    checkOutput("ovr tx adr", logAdr[txBase], 32'h3000_0070);
    checkOutput("ovr tx dat", logDat[txBase], 32'h0000_0055);
    checkOutput("ovr fetches", 32'(fetchTotal - fBase), 32'd2);
    checkOutput("ovr wrap fetch", 32'(wrapFetch - wBase), 32'd0);
    checkOutput("ovr err_code", 32'(err_code_o), 32'd3);
    checkOutput("ovr err_addr", 32'(err_addr_o), 32'h3FE);

    $display("[TB] reset during WB");
    noAck = 1'b1;
    applyStimulus(10'h010);
    for (int i = 0; i < 20 && wbIf.wbm_stb_o !== 1'b1; i++) @(negedge clk);
    checkOutput("mid stb reached", 32'(wbIf.wbm_stb_o), 32'd1);
    wb_rst_ni = 1'b0;
    @(negedge clk);
    checkOutput("mid cyc", 32'(wbIf.wbm_cyc_o), 32'd0);
    checkOutput("mid stb", 32'(wbIf.wbm_stb_o), 32'd0);
    checkOutput("mid we", 32'(wbIf.wbm_we_o), 32'd0);
    checkOutput("mid adr", wbIf.wbm_adr_o, 32'd0);
    checkOutput("mid dat", wbIf.wbm_dat_o, 32'd0);
    checkOutput("mid csb1", 32'(csb1), 32'd1);
    checkOutput("mid addr1", 32'(addr1), 32'd0);
    checkOutput("mid busy", 32'(busy_o), 32'd0);
    checkOutput("mid err_addr", 32'(err_addr_o), 32'd0);
    wb_rst_ni = 1'b1;
    noAck     = 1'b0;
    @(negedge clk);
    applyStimulus(10'h010);
    runScript1("rerun", 0, 15, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
